// File: rtl/sparse_sched_pkg.sv
// Shared constants, state type and LFSR helpers for the sparse index scheduler.
package sparse_sched_pkg;

    localparam logic [31:0] LFSR_TAPS     = 32'h80200003;
    localparam logic [31:0] LFSR_SEED_SUB = 32'h00000001;

    localparam int DEF_NUM_IDX   = 8;
    localparam int DEF_IDX_WIDTH = 16;
    localparam int DEF_NUM_DUMMY = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_e;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // An all-zero seed would lock the LFSR, so it is swapped for a fixed nonzero value.
    function automatic logic [31:0] seed_fix(input logic [31:0] s);
        return (s == 32'h0) ? LFSR_SEED_SUB : s;
    endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR used to pick dummy slot positions and dummy index values.
// Compiled only when DUMMY_INSERT_EN is defined.
`ifdef DUMMY_INSERT_EN
module lfsr32_galois
    import sparse_sched_pkg::*;
(
    input  logic        clk,
    input  logic        reset_i,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] state
);

    logic [31:0] state_q, state_d;

    // Load takes priority over stepping; otherwise the register holds.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed_fix(seed);
        end else if (step) begin
            state_d = lfsr_next(state_q);
        end
    end

    // State register; resets to the nonzero substitute seed.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= LFSR_SEED_SUB;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule
`endif

// File: rtl/sparse_idx_sched.sv
// Sparse index scheduler: latches a packed index list and emits it one slot per
// handshake. With DUMMY_INSERT_EN defined, LFSR-chosen dummy slots are mixed in.
module sparse_idx_sched
    import sparse_sched_pkg::*;
#(
    parameter int pNUM_IDX   = DEF_NUM_IDX,
    parameter int pIDX_WIDTH = DEF_IDX_WIDTH,
    parameter int pNUM_DUMMY = DEF_NUM_DUMMY
)(
    input  logic                           clk,
    input  logic                           reset_i,
    input  logic                           load_i,
    input  logic [pNUM_IDX*pIDX_WIDTH-1:0] idx_i,
    input  logic [31:0]                    seed_i,
    input  logic                           ready_i,
    output logic                           valid_o,
    output logic [pIDX_WIDTH-1:0]          idx_o,
    output logic                           dummy_o,
    output logic                           last_o,
    output logic                           busy_o
);

    localparam int RC_W = $clog2(pNUM_IDX + 1);

    sched_state_e                   state_q, state_d;
    logic [pNUM_IDX*pIDX_WIDTH-1:0] idx_mem_q, idx_mem_d;
    logic [RC_W-1:0]                real_cnt_q, real_cnt_d;
    logic                           valid_q, valid_d;
    logic [pIDX_WIDTH-1:0]          idx_q, idx_d;
    logic                           dummy_q, dummy_d;
    logic                           last_q, last_d;
    logic                           busy_q, busy_d;
    logic                           accept;

    assign accept = valid_q && ready_i;

`ifdef DUMMY_INSERT_EN
    localparam int DC_W = $clog2(pNUM_DUMMY + 1);

    logic [DC_W-1:0] dummy_cnt_q, dummy_cnt_d;
    logic            lfsr_load, lfsr_step;
    logic [31:0]     lfsr_state, lfsr_nxt;
    logic            unused_lfsr;

    assign lfsr_load   = (state_q == IDLE) && load_i;
    assign lfsr_step   = accept;
    assign unused_lfsr = ^lfsr_nxt[31:pIDX_WIDTH+1];

    lfsr32_galois u_lfsr (
        .clk     (clk),
        .reset_i (reset_i),
        .load    (lfsr_load),
        .seed    (seed_i),
        .step    (lfsr_step),
        .state   (lfsr_state)
    );

    // Mirror of the LFSR's next value so the registered slot outputs track it.
    always_comb begin
        lfsr_nxt = lfsr_state;
        if (lfsr_load) begin
            lfsr_nxt = seed_fix(seed_i);
        end else if (lfsr_step) begin
            lfsr_nxt = lfsr_next(lfsr_state);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{seed_i, 32'(pNUM_DUMMY)};
`endif

    // Next-state, counter updates, and decode of the next slot from the updated counters.
    always_comb begin
        state_d    = state_q;
        idx_mem_d  = idx_mem_q;
        real_cnt_d = real_cnt_q;
        valid_d    = 1'b0;
        idx_d      = '0;
        dummy_d    = 1'b0;
        last_d     = 1'b0;
        busy_d     = 1'b0;
`ifdef DUMMY_INSERT_EN
        dummy_cnt_d = dummy_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_i) begin
                    state_d    = RUN;
                    idx_mem_d  = idx_i;
                    real_cnt_d = RC_W'(pNUM_IDX);
`ifdef DUMMY_INSERT_EN
                    dummy_cnt_d = DC_W'(pNUM_DUMMY);
`endif
                end
            end
            RUN: begin
                if (accept) begin
                    if (last_q) begin
                        state_d    = IDLE;
                        real_cnt_d = '0;
                        idx_mem_d  = '0;
`ifdef DUMMY_INSERT_EN
                        dummy_cnt_d = '0;
`endif
                    end else if (!dummy_q) begin
                        real_cnt_d = real_cnt_q - 1'b1;
                        idx_mem_d  = idx_mem_q >> pIDX_WIDTH;
                    end
`ifdef DUMMY_INSERT_EN
                    else begin
                        dummy_cnt_d = dummy_cnt_q - 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == RUN) begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            idx_d   = idx_mem_d[pIDX_WIDTH-1:0];
`ifdef DUMMY_INSERT_EN
            dummy_d = (real_cnt_d == '0) || ((dummy_cnt_d != '0) && lfsr_nxt[0]);
            last_d  = ((real_cnt_d == RC_W'(1)) && (dummy_cnt_d == '0)) ||
                      ((real_cnt_d == '0) && (dummy_cnt_d == DC_W'(1)));
            if (dummy_d) begin
                idx_d = lfsr_nxt[pIDX_WIDTH:1];
            end
`else
            last_d  = (real_cnt_d == RC_W'(1));
`endif
        end
    end

    // State, latched indices, counters and registered outputs.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            idx_mem_q  <= '0;
            real_cnt_q <= '0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            dummy_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef DUMMY_INSERT_EN
            dummy_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_mem_q  <= idx_mem_d;
            real_cnt_q <= real_cnt_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            dummy_q    <= dummy_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
`ifdef DUMMY_INSERT_EN
            dummy_cnt_q <= dummy_cnt_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign idx_o   = idx_q;
    assign dummy_o = dummy_q;
    assign last_o  = last_q;
    assign busy_o  = busy_q;

endmodule
